tlb_op_ctrl: RTL and testbench

Sequencer for the CP0 TLB instructions (TLBR, TLBWI, TLBWR, TLBP). It sits between the CP0/execute stage and the mmu's `tlbrw_*` / `tlbp_*` ports. It owns the CP0 Random and Wired registers and runs each operation as a fixed multi-cycle transaction with valid/ready handshakes on both sides. After every TLB write it emits a one-cycle flush pulse so the pipeline refetches under the new mapping.

---
 rtl/tlb_op_ctrl_if.sv | 36 +++
 rtl/tlb_op_ctrl.sv | 87 ++++++++
 tb/tb_tlb_op_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/tlb_op_ctrl_if.sv
// tlb_op_ctrl_if: request/response handshake between the CP0/execute stage and the TLB op sequencer
// Ports:
//   req_valid/req_ready : request handshake
//   req_op              : 00 TLBR, 01 TLBWI, 10 TLBWR, 11 TLBP
//   req_index           : CP0 Index
//   req_entry           : TLB write data
//   req_entry_hi        : CP0 EntryHi probe key
//   resp_valid/ready    : response handshake
//   resp_op             : echo of the accepted op
//   resp_entry          : TLBR read data
//   resp_index          : TLBP result (bit 31 = miss)
interface tlb_op_ctrl_if #(
  parameter int N_TLB_ENTRIES = 32,
  parameter int ENTRY_W = 64
);
  localparam int IDX_W = $clog2(N_TLB_ENTRIES);
  logic req_valid;
  logic req_ready;
  logic [1:0] req_op;
  logic [IDX_W-1:0] req_index;
  logic [ENTRY_W-1:0] req_entry;
  logic [31:0] req_entry_hi;
  logic resp_valid;
  logic resp_ready;
  logic [1:0] resp_op;
  logic [ENTRY_W-1:0] resp_entry;
  logic [31:0] resp_index;
  modport master (
    output req_valid, req_op, req_index, req_entry, req_entry_hi, resp_ready,
    input req_ready, resp_valid, resp_op, resp_entry, resp_index
  );
  modport slave (
    input req_valid, req_op, req_index, req_entry, req_entry_hi, resp_ready,
    output req_ready, resp_valid, resp_op, resp_entry, resp_index
  );
endinterface

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequencer for TLBR/TLBWI/TLBWR/TLBP, owning CP0 Random and Wired
// Ports:
//   clk, rst (async, active-low)
//   bus           : request/response handshake (tlb_op_ctrl_if.slave)
//   wired_we/wdata: CP0 Wired write
//   random, wired : current CP0 Random / Wired
//   tlbrw_*       : mmu read/write port (rddata combinational from tlbrw_index)
//   tlbp_*        : mmu probe port (tlbp_index combinational from tlbp_entry_hi)
//   tlb_wr_flush  : one-cycle pulse after each TLB write
// Build option: define TLB_OP_CTRL_WIRED_EN to implement the Wired register;
// otherwise wired is 0 and Random free-runs over the whole TLB.
module tlb_op_ctrl #(
  parameter int N_TLB_ENTRIES = 32,
  parameter int ENTRY_W = 64,
  localparam int IDX_W = $clog2(N_TLB_ENTRIES)
) (
  input  logic clk,
  input  logic rst,
  tlb_op_ctrl_if.slave bus,
  input  logic wired_we,
  input  logic [IDX_W-1:0] wired_wdata,
  output logic [IDX_W-1:0] random,
  output logic [IDX_W-1:0] wired,
  output logic [IDX_W-1:0] tlbrw_index,
  output logic tlbrw_we,
  output logic [ENTRY_W-1:0] tlbrw_wrdata,
  input  logic [ENTRY_W-1:0] tlbrw_rddata,
  output logic [31:0] tlbp_entry_hi,
  input  logic [31:0] tlbp_index,
  output logic tlb_wr_flush
);
  typedef enum logic [2:0] {IDLE, READ, WRITE, PROBE, RESP, FLUSH} state_t;
  localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(N_TLB_ENTRIES - 1);
  state_t state, state_nx;
  logic accept, wired_wr;
  assign accept = bus.req_valid & bus.req_ready;
  assign bus.req_ready = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign tlbrw_we = state == WRITE;
  assign tlb_wr_flush = state == FLUSH;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  // write ops are 01 and 10, so the two op bits differ exactly for writes
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = bus.req_op == 2'b00 ? READ : bus.req_op == 2'b11 ? PROBE : WRITE;
      READ, WRITE, PROBE: state_nx = RESP;
      RESP: if (bus.resp_ready) state_nx = (bus.resp_op[1] ^ bus.resp_op[0]) ? FLUSH : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // result fields are cleared on accept so non-matching ops report zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.resp_op <= '0;
      bus.resp_entry <= '0;
      bus.resp_index <= '0;
      tlbrw_index <= '0;
      tlbrw_wrdata <= '0;
      tlbp_entry_hi <= '0;
    end else if (accept) begin
      bus.resp_op <= bus.req_op;
      bus.resp_entry <= '0;
      bus.resp_index <= '0;
      tlbrw_index <= bus.req_op == 2'b10 ? random : bus.req_index;
      tlbrw_wrdata <= bus.req_entry;
      tlbp_entry_hi <= bus.req_entry_hi;
    end else if (state == READ) bus.resp_entry <= tlbrw_rddata;
    else if (state == PROBE) bus.resp_index <= tlbp_index;
`ifdef TLB_OP_CTRL_WIRED_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) wired <= '0;
    else if (wired_we) wired <= wired_wdata;
  assign wired_wr = wired_we;
`else
  logic unused_wired;
  assign unused_wired = ^{wired_we, wired_wdata};
  assign wired = '0;
  assign wired_wr = 1'b0;
`endif
  // with wired fixed at 0 the wrap test reduces to a plain 0 -> MAX wrap
  always_ff @(posedge clk or negedge rst)
    if (!rst) random <= MAX_IDX;
    else random <= (wired_wr || random == wired || wired >= MAX_IDX) ? MAX_IDX : random - IDX_W'(1);
endmodule

// File: tb/tb_tlb_op_ctrl.sv
// tb_tlb_op_ctrl: directed + randomized bench for tlb_op_ctrl with an mmu model and reference model
module tb_tlb_op_ctrl;
  localparam int N = 32, EW = 64, IW = 5;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  tlb_op_ctrl_if #(.N_TLB_ENTRIES(N), .ENTRY_W(EW)) bus ();
  logic wired_we = 0;
  logic [IW-1:0] wired_wdata = '0;
  logic [IW-1:0] random, wired, tlbrw_index;
  logic tlbrw_we, tlb_wr_flush;
  logic [EW-1:0] tlbrw_wrdata, tlbrw_rddata;
  logic [31:0] tlbp_entry_hi, tlbp_index;
  tlb_op_ctrl #(.N_TLB_ENTRIES(N), .ENTRY_W(EW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .wired_we(wired_we), .wired_wdata(wired_wdata),
    .random(random), .wired(wired),
    .tlbrw_index(tlbrw_index), .tlbrw_we(tlbrw_we), .tlbrw_wrdata(tlbrw_wrdata),
    .tlbrw_rddata(tlbrw_rddata), .tlbp_entry_hi(tlbp_entry_hi), .tlbp_index(tlbp_index),
    .tlb_wr_flush(tlb_wr_flush)
  );
  function automatic logic [EW-1:0] init_val(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
  endfunction
  // mmu model: combinational read and probe, write on the clock edge
  logic [EW-1:0] mmu_mem [N];
  logic [N-1:0] mmu_vld = '0;
  function automatic logic [EW-1:0] mmu_rd(input int i);
    return mmu_vld[i] ? mmu_mem[i] : init_val(i);
  endfunction
  assign tlbrw_rddata = mmu_rd(int'(tlbrw_index));
  always_comb begin
    tlbp_index = 32'h8000_0000;
    for (int i = N - 1; i >= 0; i--)
      if (mmu_rd(i) [31:0] == tlbp_entry_hi) tlbp_index = 32'(i);
  end
  always @(posedge clk)
    if (tlbrw_we) begin
      mmu_mem[tlbrw_index] <= tlbrw_wrdata;
      mmu_vld[tlbrw_index] <= 1'b1;
    end
  // reference model: Random is an arithmetic function of cycles since the last reset/Wired write
  logic [EW-1:0] ref_mem [N];
  int cyc = 0, wired_m = 0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      cyc <= 0;
      wired_m <= 0;
    end
`ifdef TLB_OP_CTRL_WIRED_EN
    else if (wired_we) begin
      cyc <= 0;
      wired_m <= int'(wired_wdata);
    end
`endif
    else cyc <= cyc + 1;
  function automatic int exp_random();
    return wired_m >= N - 1 ? N - 1 : N - 1 - cyc % (N - wired_m);
  endfunction
  function automatic logic [31:0] probe_ref(input logic [31:0] key);
    for (int i = 0; i < N; i++)
      if (ref_mem[i][31:0] == key) return 32'(i);
    return 32'h8000_0000;
  endfunction
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_regs();
    chk("random", 64'(random), 64'(exp_random()));
    chk("wired", 64'(wired), 64'(wired_m));
  endtask
  task automatic do_op(input logic [1:0] op, input logic [4:0] idx, input logic [63:0] ent,
                       input logic [31:0] ehi, input int hold);
    logic [4:0] xi;
    logic [63:0] xe;
    logic [31:0] xp;
    bit wr;
    wr = op == 2'b01 || op == 2'b10;
    xi = op == 2'b10 ? 5'(exp_random()) : idx;
    xe = op == 2'b00 ? ref_mem[xi] : '0;
    xp = op == 2'b11 ? probe_ref(ehi) : '0;
    chk("req_ready_idle", 64'(bus.req_ready), 1);
    bus.req_valid = 1;
    bus.req_op = op;
    bus.req_index = idx;
    bus.req_entry = ent;
    bus.req_entry_hi = ehi;
    @(negedge clk);
    bus.req_valid = 0;
    bus.req_index = 5'($urandom);
    bus.req_entry = {$urandom, $urandom};
    bus.req_entry_hi = $urandom;
    chk("access_we", 64'(tlbrw_we), 64'(wr));
    chk("req_ready_busy", 64'(bus.req_ready), 0);
    chk("resp_valid_early", 64'(bus.resp_valid), 0);
    if (op != 2'b11) chk("tlbrw_index", 64'(tlbrw_index), 64'(xi));
    if (wr) chk("tlbrw_wrdata", tlbrw_wrdata, ent);
    if (op == 2'b11) chk("tlbp_entry_hi", 64'(tlbp_entry_hi), 64'(ehi));
    @(negedge clk);
    chk("resp_valid", 64'(bus.resp_valid), 1);
    chk("resp_op", 64'(bus.resp_op), 64'(op));
    for (int k = 0; k < hold; k++) begin
      chk("hold_entry", bus.resp_entry, xe);
      chk("hold_index", 64'(bus.resp_index), 64'(xp));
      chk("hold_valid", 64'(bus.resp_valid), 1);
      chk("hold_req_ready", 64'(bus.req_ready), 0);
      chk("hold_we", 64'(tlbrw_we), 0);
      chk("hold_flush", 64'(tlb_wr_flush), 0);
      @(negedge clk);
    end
    chk("resp_entry", bus.resp_entry, xe);
    chk("resp_index", 64'(bus.resp_index), 64'(xp));
    bus.resp_ready = 1;
    @(negedge clk);
    bus.resp_ready = 0;
    chk("resp_valid_drop", 64'(bus.resp_valid), 0);
    chk("flush", 64'(tlb_wr_flush), 64'(wr));
    if (wr) begin
      ref_mem[xi] = ent;
      chk("req_ready_flush", 64'(bus.req_ready), 0);
      @(negedge clk);
      chk("flush_once", 64'(tlb_wr_flush), 0);
    end
    chk("req_ready_back", 64'(bus.req_ready), 1);
  endtask
  initial begin
    logic [63:0] e;
    int seq [5];
    int guard;
    for (int i = 0; i < N; i++) ref_mem[i] = init_val(i);
    bus.req_valid = 0;
    bus.req_op = '0;
    bus.req_index = '0;
    bus.req_entry = '0;
    bus.req_entry_hi = '0;
    bus.resp_ready = 0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 64'(bus.resp_valid), 0);
    chk("rst_we", 64'(tlbrw_we), 0);
    chk("rst_flush", 64'(tlb_wr_flush), 0);
    chk("rst_index", 64'(tlbrw_index), 0);
    chk("rst_wrdata", tlbrw_wrdata, 0);
    chk("rst_ehi", 64'(tlbp_entry_hi), 0);
    chk("rst_resp_entry", bus.resp_entry, 0);
    chk("rst_resp_index", 64'(bus.resp_index), 0);
    chk("rst_random", 64'(random), 31);
    chk("rst_wired", 64'(wired), 0);
    rst = 1;
    chk("rel_req_ready", 64'(bus.req_ready), 1);
    chk("rel_random", 64'(random), 31);
    repeat (10) @(negedge clk);
    chk("random_10", 64'(random), 21);
    chk_regs();
    e = {$urandom, $urandom};
    do_op(2'b01, 5'd5, e, 32'h0, 0);
    do_op(2'b00, 5'd5, 64'h0, 32'h0, 0);
    chk("read_back_5", ref_mem[5], e);
    do_op(2'b11, 5'd0, 64'h0, ref_mem[7][31:0], 0);
    do_op(2'b11, 5'd0, 64'h0, 32'hDEAD_BEEF, 1);
    chk_regs();
    wired_we = 1;
    wired_wdata = 5'd28;
    @(negedge clk);
    wired_we = 0;
    seq = '{31, 30, 29, 28, 31};
    for (int k = 0; k < 5; k++) begin
`ifdef TLB_OP_CTRL_WIRED_EN
      chk("wired_seq", 64'(random), 64'(seq[k]));
`endif
      chk_regs();
      @(negedge clk);
    end
    guard = 0;
    while (exp_random() != 29 && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    chk("random_29", 64'(random), 29);
    do_op(2'b10, 5'd3, {$urandom, $urandom}, 32'h0, 0);
    do_op(2'b00, 5'd29, 64'h0, 32'h0, 0);
    for (int it = 0; it < 25; it++) begin
      logic [1:0] op;
      logic [31:0] key;
      if ($urandom_range(0, 3) == 0) begin
        wired_we = 1;
        wired_wdata = 5'($urandom_range(0, 31));
        @(negedge clk);
        wired_we = 0;
      end
      chk_regs();
      op = 2'($urandom_range(0, 3));
      key = $urandom_range(0, 1) ? ref_mem[$urandom_range(0, N - 1)][31:0] : $urandom;
      do_op(op, 5'($urandom), {$urandom, $urandom}, key, $urandom_range(0, 3));
      chk_regs();
    end
    do_op(2'b00, 5'd5, 64'h0, 32'h0, 5);
    bus.req_valid = 1;
    bus.req_op = 2'b01;
    bus.req_index = 5'd9;
    bus.req_entry = {$urandom, $urandom};
    @(negedge clk);
    bus.req_valid = 0;
    chk("mid_we", 64'(tlbrw_we), 1);
    rst = 0;
    #1;
    chk("async_we_drop", 64'(tlbrw_we), 0);
    chk("async_idle", 64'(bus.req_ready), 1);
    chk("async_resp", 64'(bus.resp_valid), 0);
    @(negedge clk);
    rst = 1;
    bus.resp_ready = 1;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_resp", 64'(bus.resp_valid), 0);
      chk("post_rst_flush", 64'(tlb_wr_flush), 0);
      chk("post_rst_we", 64'(tlbrw_we), 0);
    end
    bus.resp_ready = 0;
    chk_regs();
    do_op(2'b00, 5'd9, 64'h0, 32'h0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
